// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared FSM states and MC6850 register-map constants for uart_bus_ctrl
package uart_ctrl_pkg;
  typedef enum logic [2:0] {INIT_RST, INIT_CFG, WAIT, POLL, TXWR, RXRD, GAP} state_t;
  localparam int STAT_RDRF = 0;
  localparam int STAT_TDRE = 1;
  localparam int STAT_IRQ = 7;
  localparam logic [7:0] CTRL_MRESET = 8'h03;
  localparam logic REGSEL_CTRL = 1'b0;
  localparam logic REGSEL_DATA = 1'b1;
endpackage

// File: rtl/uart_bus_ctrl_if.sv
// uart_bus_ctrl_if: MC6850 register port (cs_b, rnw, regsel, wdata driven by the master; rdata by the UART)
interface uart_bus_ctrl_if;
  logic cs_b;
  logic rnw;
  logic regsel;
  logic [7:0] wdata;
  logic [7:0] rdata;
  modport master (output cs_b, rnw, regsel, wdata, input rdata);
  modport slave (input cs_b, rnw, regsel, wdata, output rdata);
endinterface

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2: two-input round-robin arbiter
// Ports: clk, reset_b (async, active-low), req[1:0], upd (commit grant), gnt[1:0] one-hot, last (last granted index)
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       last
);
  assign gnt = &req ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) last <= 1'b1;
    else if (upd) last <= gnt[1];
endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: autonomous MC6850 bus master - optional init, status polling, 2-way RR transmit, valid/ready receive
// Ports: clk, reset_b (async, active-low), u (UART register port, master), tx0/tx1 req/data/ack,
//        rx_valid/rx_data/rx_ready, init_done. Macro UART_BUS_CTRL_INIT_EN enables the master-reset/config writes.
module uart_bus_ctrl import uart_ctrl_pkg::*; #(
  parameter logic [7:0]  CTRL_INIT = 8'h95,
  parameter int unsigned POLL_DIV  = 0
) (
  input  logic                   clk,
  input  logic                   reset_b,
  uart_bus_ctrl_if.master        u,
  input  logic                   tx0_req,
  input  logic [7:0]             tx0_data,
  output logic                   tx0_ack,
  input  logic                   tx1_req,
  input  logic [7:0]             tx1_data,
  output logic                   tx1_ack,
  output logic                   rx_valid,
  output logic [7:0]             rx_data,
  input  logic                   rx_ready,
  output logic                   init_done
);
  state_t st, st_n, idle_n;
  logic [7:0] cnt;
  logic [1:0] req, gnt;
  logic wait_done, upd, acc, wr, last_unused;
  assign req = {tx1_req, tx0_req};
  assign idle_n = (POLL_DIV == 0) ? POLL : WAIT;
  assign wait_done = 9'(cnt) + 9'd1 >= 9'(POLL_DIV);
  assign upd = st_n == TXWR;
  assign acc = st_n inside {INIT_RST, INIT_CFG, POLL, TXWR, RXRD};
  assign wr = st_n inside {INIT_RST, INIT_CFG, TXWR};
  uart_rr_arb2 arb (.clk(clk), .reset_b(reset_b), .req(req), .upd(upd), .gnt(gnt), .last(last_unused));
  // Reset parks in WAIT with init_done low; with init enabled that combination launches the init writes.
  always_comb begin
    st_n = st;
    case (st)
      INIT_RST: st_n = INIT_CFG;
      INIT_CFG: st_n = idle_n;
`ifdef UART_BUS_CTRL_INIT_EN
      WAIT:     st_n = !init_done ? INIT_RST : wait_done ? POLL : WAIT;
`else
      WAIT:     st_n = wait_done ? POLL : WAIT;
`endif
      POLL:     st_n = u.rdata[STAT_RDRF] && !rx_valid ? RXRD : u.rdata[STAT_TDRE] && |req ? TXWR : idle_n;
      TXWR:     st_n = GAP;
      RXRD:     st_n = GAP;
      GAP:      st_n = idle_n;
      default:  st_n = WAIT;
    endcase
  end
  // Bus outputs are registered from the next state so each access spans exactly one clock period.
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      st <= WAIT;
      cnt <= '0;
      u.cs_b <= 1'b1;
      u.rnw <= 1'b1;
      u.regsel <= REGSEL_CTRL;
      u.wdata <= '0;
      tx0_ack <= 1'b0;
      tx1_ack <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      init_done <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= (st == WAIT && st_n == WAIT) ? cnt + 8'd1 : 8'd0;
      u.cs_b <= !acc;
      u.rnw <= !wr;
      u.regsel <= st_n inside {TXWR, RXRD} ? REGSEL_DATA : REGSEL_CTRL;
      u.wdata <= st_n == INIT_RST ? CTRL_MRESET : st_n == INIT_CFG ? CTRL_INIT :
                 st_n == TXWR ? (gnt[1] ? tx1_data : tx0_data) : u.wdata;
      tx0_ack <= upd & gnt[0];
      tx1_ack <= upd & gnt[1];
      rx_valid <= (st == RXRD) | (rx_valid & !rx_ready);
      rx_data <= st == RXRD ? u.rdata : rx_data;
`ifdef UART_BUS_CTRL_INIT_EN
      init_done <= init_done | (st == INIT_CFG);
`else
      init_done <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl: self-checking bench for uart_bus_ctrl with a behavioural UART register model
module tb_uart_bus_ctrl;
  logic clk = 1'b0, reset_b = 1'b1;
  logic tx0_req = 1'b0, tx1_req = 1'b0, tx0_ack, tx1_ack;
  logic [7:0] tx0_data = '0, tx1_data = '0, rx_data;
  logic rx_valid, rx_ready = 1'b0, init_done;
  logic tdre = 1'b1, rdrf = 1'b0;
  logic [7:0] rx_byte = '0;
  int checks = 0, failures = 0;

  typedef struct {
    logic r0, r1;
    logic [7:0] d0, d1, w;
    logic a0, a1;
  } vec_t;
  typedef struct packed {
    logic [7:0] w;
    logic a0, a1;
  } exp_t;
  vec_t tbl[7];
  exp_t sb[$];

  uart_bus_ctrl_if bus();
  assign bus.rdata = bus.regsel ? rx_byte : {6'b0, tdre, rdrf};

  uart_bus_ctrl #(.CTRL_INIT(8'h95), .POLL_DIV(0)) dut (
    .clk(clk), .reset_b(reset_b), .u(bus),
    .tx0_req(tx0_req), .tx0_data(tx0_data), .tx0_ack(tx0_ack),
    .tx1_req(tx1_req), .tx1_data(tx1_data), .tx1_ack(tx1_ack),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_data(input logic rd, input string nm);
    int n = 0;
    @(negedge clk);
    while (!(bus.cs_b == 1'b0 && bus.regsel == 1'b1 && bus.rnw == rd) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 32'(n >= 50), 0);
  endtask

  task automatic pop_chk(input string nm);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected write actual=%0h expected=none", nm, bus.wdata);
    end else begin
      checks--;
      e = sb.pop_front();
      chk({nm, "_wdata"}, 32'(bus.wdata), 32'(e.w));
      chk({nm, "_ack0"}, 32'(tx0_ack), 32'(e.a0));
      chk({nm, "_ack1"}, 32'(tx1_ack), 32'(e.a1));
    end
  endtask

  task automatic chk_init(input string nm);
`ifdef UART_BUS_CTRL_INIT_EN
    @(negedge clk);
    chk({nm, "_mrst_bus"}, {29'b0, bus.cs_b, bus.rnw, bus.regsel}, 32'b000);
    chk({nm, "_mrst_data"}, 32'(bus.wdata), 32'h03);
    chk({nm, "_mrst_done"}, 32'(init_done), 0);
    @(negedge clk);
    chk({nm, "_cfg_bus"}, {29'b0, bus.cs_b, bus.rnw, bus.regsel}, 32'b000);
    chk({nm, "_cfg_data"}, 32'(bus.wdata), 32'h95);
    chk({nm, "_cfg_done"}, 32'(init_done), 0);
`endif
    @(negedge clk);
    chk({nm, "_poll1_bus"}, {29'b0, bus.cs_b, bus.rnw, bus.regsel}, 32'b010);
    chk({nm, "_poll1_done"}, 32'(init_done), 1);
    @(negedge clk);
    chk({nm, "_poll2_bus"}, {29'b0, bus.cs_b, bus.rnw, bus.regsel}, 32'b010);
  endtask

  initial begin
    int reads;
    tbl[0] = '{1'b1, 1'b0, 8'h41, 8'h00, 8'h41, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h22, 8'h22, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h11, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h33, 8'h44, 8'h44, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'h55, 8'h66, 8'h55, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h77, 8'h00, 8'h77, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h88, 8'h99, 8'h99, 1'b0, 1'b1};
    #1 reset_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bus", {29'b0, bus.cs_b, bus.rnw, bus.regsel}, 32'b110);
    chk("rst_wdata", 32'(bus.wdata), 0);
    chk("rst_flags", {28'b0, tx0_ack, tx1_ack, rx_valid, init_done}, 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    reset_b = 1'b1;
    chk_init("init");

    foreach (tbl[i]) begin
      tx0_req = tbl[i].r0; tx1_req = tbl[i].r1;
      tx0_data = tbl[i].d0; tx1_data = tbl[i].d1;
      sb.push_back('{tbl[i].w, tbl[i].a0, tbl[i].a1});
      wait_data(1'b0, $sformatf("vec%0d", i));
      pop_chk($sformatf("vec%0d", i));
      tx0_req = 1'b0; tx1_req = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_gap", i), {29'b0, bus.cs_b, tx0_ack, tx1_ack}, 32'b100);
      @(negedge clk);
      chk($sformatf("vec%0d_poll", i), {29'b0, bus.cs_b, bus.rnw, bus.regsel}, 32'b010);
    end

    tx0_req = 1'b1; tx1_req = 1'b1; tx0_data = 8'h11; tx1_data = 8'h22;
    for (int k = 0; k < 4; k++) sb.push_back('{(k % 2 == 0) ? 8'h11 : 8'h22, k % 2 == 0, k % 2 == 1});
    for (int k = 0; k < 4; k++) begin
      wait_data(1'b0, $sformatf("alt%0d", k));
      pop_chk($sformatf("alt%0d", k));
      if (k == 3) begin tx0_req = 1'b0; tx1_req = 1'b0; end
      @(negedge clk);
      chk($sformatf("alt%0d_single_ack", k), {30'b0, tx0_ack, tx1_ack}, 0);
    end

    rdrf = 1'b1; rx_byte = 8'hC3; tx1_req = 1'b1; tx1_data = 8'h5A;
    sb.push_back('{8'h5A, 1'b0, 1'b1});
    wait_data(1'b1, "rx_first");
    chk("rx_valid_during_read", 32'(rx_valid), 0);
    @(negedge clk);
    chk("rx_valid_rise", 32'(rx_valid), 1);
    chk("rx_data_c3", 32'(rx_data), 32'hC3);
    wait_data(1'b0, "tx_after_rx");
    pop_chk("tx_after_rx");
    tx1_req = 1'b0;
    reads = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.cs_b && bus.rnw && bus.regsel) reads++;
    end
    chk("rx_no_reread", 32'(reads), 0);
    chk("rx_hold_valid", 32'(rx_valid), 1);
    chk("rx_hold_data", 32'(rx_data), 32'hC3);
    rx_byte = 8'h7E; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx_valid_clear", 32'(rx_valid), 0);
    wait_data(1'b1, "rx_second");
    @(negedge clk);
    chk("rx2_valid", 32'(rx_valid), 1);
    chk("rx2_data", 32'(rx_data), 32'h7E);
    rdrf = 1'b0; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx2_drain", 32'(rx_valid), 0);

    tx0_req = 1'b1; tx0_data = 8'hAA;
    sb.push_back('{8'hAA, 1'b1, 1'b0});
    wait_data(1'b0, "tx_rst");
    pop_chk("tx_rst");
    #2 reset_b = 1'b0;
    #1;
    chk("midrst_cs_b", 32'(bus.cs_b), 1);
    chk("midrst_ack0", 32'(tx0_ack), 0);
    chk("midrst_wdata", 32'(bus.wdata), 0);
    chk("midrst_done", 32'(init_done), 0);
    tx0_req = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    chk_init("reinit");
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
